// File: rtl/alu_mc_if.sv
// Handshake and data bundle between an ALU producer/consumer and alu_mc.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             z_f;
  logic             n_f;
  logic             v_f;
  logic             c_f;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, z_f, n_f, v_f, c_f, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, z_f, n_f, v_f, c_f, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add/shift ops, iterative mul/div
// (one shift-add or restoring-subtract step per cycle), valid/ready handshake.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opd_q, opd_d;     // multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;       // product high half or partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier/product low half or quotient
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;

  logic [WIDTH-1:0] b_n;
  logic [WIDTH:0]   add_s, sub_s;
  logic             add_v, sub_v;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] fast_r;
  logic             fast_v, fast_c, fast_en;
  logic             is_iter;

  logic             is_mul;
  logic [WIDTH:0]   psum;
  logic [WIDTH:0]   dshift;
  logic             dge;
  logic [WIDTH-1:0] step_hi, step_lo, iter_r;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.z_f       = z_q;
  assign bus.n_f       = n_q;
  assign bus.v_f       = v_q;
  assign bus.c_f       = c_q;

  // Single-cycle datapath evaluated on the live operands at accept time.
  always_comb begin
    b_n     = ~bus.b;
    add_s   = {1'b0, bus.a} + {1'b0, bus.b};
    sub_s   = {1'b0, bus.a} + {1'b0, b_n} + (WIDTH+1)'(1);
    add_v   = (bus.a[MSB] == bus.b[MSB]) && (add_s[MSB] != bus.a[MSB]);
    sub_v   = (bus.a[MSB] == b_n[MSB])   && (sub_s[MSB] != bus.a[MSB]);
    sh      = bus.b[SHW-1:0];
    fast_r  = '0;
    fast_v  = 1'b0;
    fast_c  = 1'b0;
    fast_en = (bus.op < 4'd10);
    is_iter = (bus.op >= 4'd10) && (bus.op <= 4'd13);
    case (bus.op)
      4'd0: begin fast_r = add_s[MSB:0]; fast_c = add_s[WIDTH]; fast_v = add_v; end
      4'd1: begin fast_r = sub_s[MSB:0]; fast_c = sub_s[WIDTH]; fast_v = sub_v; end
      4'd2: fast_r = bus.a & bus.b;
      4'd3: fast_r = bus.a | bus.b;
      4'd4: fast_r = bus.a ^ bus.b;
      4'd5: fast_r = {{(WIDTH-1){1'b0}}, sub_s[MSB] ^ sub_v};
      4'd6: fast_r = {{(WIDTH-1){1'b0}}, ~sub_s[WIDTH]};
      4'd7: fast_r = bus.a << sh;
      4'd8: fast_r = bus.a >> sh;
      4'd9: fast_r = $signed(bus.a) >>> sh;
      default: fast_r = '0;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide.
  always_comb begin
    is_mul = (op_q[3:1] == 3'b101);
    psum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    dshift = {hi_q, lo_q[MSB]};
    dge    = (dshift >= {1'b0, opd_q});
    if (is_mul) begin
      step_hi = psum[WIDTH:1];
      step_lo = {psum[0], lo_q[MSB:1]};
    end else begin
      step_hi = dge ? WIDTH'(dshift - {1'b0, opd_q}) : dshift[MSB:0];
      step_lo = {lo_q[MSB-1:0], dge};
    end
    // MUL/DIVU take the low/quotient half, MULHU/REMU the high/remainder half.
    iter_r = op_q[0] ? step_hi : step_lo;
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opd_d    = opd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    c_d      = c_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.op;
          if (is_iter) begin
            state_d = CALC;
            cnt_d   = '0;
            hi_d    = '0;
            if (bus.op[3:1] == 3'b101) begin
              opd_d = bus.a;
              lo_d  = bus.b;
            end else begin
              opd_d = bus.b;
              lo_d  = bus.a;
            end
          end else begin
            state_d  = DONE;
            result_d = fast_r;
            z_d      = fast_en && (fast_r == '0);
            n_d      = fast_en && fast_r[MSB];
            v_d      = fast_v;
            c_d      = fast_c;
          end
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = iter_r;
          z_d      = (iter_r == '0);
          n_d      = iter_r[MSB];
          v_d      = 1'b0;
          c_d      = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      opd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      op_q     <= op_d;
      opd_q    <= opd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      c_q      <= c_d;
    end
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width; it is derived from WIDTH and SHALL NOT be overridden.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  in  1  operand/opcode presented.
REQ-006 SHALL have port in_ready  out  1  block can accept an operation.
REQ-007 SHALL have port a  in  WIDTH  operand A.
REQ-008 SHALL have port b  in  WIDTH  operand B.
REQ-009 SHALL have port op  in  4  operation select.
REQ-010 SHALL have port out_valid  out  1  result and flags valid.
REQ-011 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-012 SHALL have port result  out  WIDTH  registered result.
REQ-013 SHALL have ports z_f, n_f, v_f, c_f  out  1 each  registered zero, negative, overflow and carry flags.
REQ-014 SHALL have port busy  out  1  high while state is not IDLE.

Function
REQ-015 Opcodes SHALL be as follows:
- 0 ADD; 1 SUB (a+~b+1); 2 AND; 3 OR; 4 XOR.
- 5 SLT: signed compare, result {0..0, N^V of a-b}.
- 6 SLTU: result {0..0, ~carry of a-b}.
- 7 SLL, 8 SRL, 9 SRA: shift amount b[SHW-1:0].
- 10 MUL: low WIDTH bits of the unsigned product; 11 MULHU: high WIDTH bits of the unsigned product.
- 12 DIVU: unsigned quotient; 13 REMU: unsigned remainder.
- 14, 15: result 0 and all flags 0.
REQ-016 The FSM SHALL have the states IDLE, CALC and DONE; in_ready = (state==IDLE).
REQ-017 A transaction SHALL be accepted on a rising edge with in_valid&&in_ready; a, b and op are captured at that edge.
REQ-018 Opcodes 0-9 and 14-15 SHALL go from IDLE to DONE with the result registered at the accept edge, so out_valid is high after 1 edge.
REQ-019 Opcodes 10-13 SHALL go from IDLE to CALC and perform one shift-add (MUL) or one restoring-subtract (DIV) step per cycle for exactly WIDTH cycles, then go to DONE; out_valid SHALL be high WIDTH+1 edges after accept.
REQ-020 In DONE, out_valid SHALL be 1, and result and flags SHALL be held stable until out_valid&&out_ready; the FSM then returns to IDLE on that edge.
REQ-021 in_valid while not in IDLE SHALL be ignored, and the operands SHALL NOT be sampled.
REQ-022 Divide by zero (b==0) SHALL run the full WIDTH cycles and give DIVU = all ones and REMU = a.
REQ-023 z_f SHALL be (result==0) and n_f SHALL be result[WIDTH-1], for every opcode 0-13.
REQ-024 c_f SHALL be the carry-out of the WIDTH-bit adder for ADD/SUB and SHALL be 0 otherwise; for SUB, c_f=1 means no borrow (a>=b unsigned).
REQ-025 v_f SHALL be signed overflow for ADD/SUB only: (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), with b'=~b for SUB; v_f SHALL be 0 otherwise.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH, except MULHU, which uses the full 2*WIDTH product.
REQ-027 The iteration counter SHALL be SHW+1 bits wide and SHALL reset to 0 on entry to CALC.

Reset
REQ-028 While rst_n==0, state SHALL be IDLE, result=0, all flags 0, out_valid=0, busy=0, counter 0 and internal operand registers 0; in_ready SHALL read 1 as soon as rst_n is released.
REQ-029 Reset asserted in CALC or DONE SHALL abort the operation immediately (asynchronously), with no result delivered after release.

Verification (WIDTH=32)
REQ-030 ADD with a=0x7FFFFFFF, b=1, out_ready=1 -> after 1 edge, result=0x80000000, v_f=1, n_f=1, c_f=0, z_f=0.
REQ-031 SUB with a=5, b=5 -> result=0, z_f=1, c_f=1; SLT with a=0xFFFFFFFF, b=1 -> result=1; SLTU with the same operands -> result=0.
REQ-032 MUL with a=0xFFFFFFFF, b=2 -> out_valid exactly 33 edges after accept, result=0xFFFFFFFE; MULHU with the same operands -> result=1.
REQ-033 DIVU with a=100, b=0 -> result=0xFFFFFFFF; REMU with a=100, b=7 -> result=2; in_ready=0 for the full 33 cycles, and in_valid pulses during that time are ignored.
REQ-034 Backpressure: SRA with a=0x80000000, b=4 and out_ready held 0 for 5 cycles -> result=0xF8000000 stable with out_valid=1 throughout; IDLE is entered on the edge where out_ready=1.
REQ-035 rst_n pulsed low at CALC cycle 10 of a DIVU -> out_valid=0, busy=0, result=0 immediately; a subsequent ADD with a=1, b=2 completes with result=3.
